// File: rtl/count_stream_checker.sv
// Stream monitor for a free-running counter: checks each sample is previous+1 and logs mismatches to a FIFO.
// Optional macro COUNT_CHECK_DISPLAY_EN adds simulation messages on mismatch and overflow drop.
//
// state | meaning
// IDLE  | waiting for the first enabled sample to seed the expected value
// TRACK | checking every enabled sample against expected; left only by reset
module count_stream_checker #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             sample_en,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_actual,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_total,
  output logic             overflow,
  output logic             tracking
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [0:0]         state;
  logic [WIDTH-1:0]   expected;
  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;

  logic mismatch, match, pop, full, push_ok, drop;
  logic [WIDTH-1:0]   next_exp;
  logic [2*WIDTH-1:0] head;

  assign next_exp = count_in + WIDTH'(1);
  assign match    = sample_en && (state == TRACK) && (count_in == expected);
  assign mismatch = sample_en && (state == TRACK) && (count_in != expected);
  assign full     = (count == DEPTH_C);
  assign pop      = err_valid && err_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok  = mismatch && (!full || pop);
  assign drop     = mismatch && full && !pop;

  assign err_valid    = (count != '0);
  assign head         = mem[rd_ptr];
  assign err_expected = err_valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign err_actual   = err_valid ? head[WIDTH-1:0] : '0;
  assign tracking     = (state == TRACK);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {expected, count_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      expected   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wrap_count <= '0;
      err_total  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (sample_en) begin
        state    <= TRACK;
        expected <= next_exp;
      end
      if (match && (count_in == ALL_ONES) && (wrap_count != CNT_MAX))
        wrap_count <= wrap_count + CNT_W'(1);
      if (mismatch && (err_total != CNT_MAX))
        err_total <= err_total + CNT_W'(1);
      if (drop) overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
`ifdef COUNT_CHECK_DISPLAY_EN
      if (mismatch) $display("CHECK ERR t=%t exp=%d act=%d", $time, expected, count_in);
      if (drop)     $display("CHECK OVERFLOW t=%t", $time);
`endif
    end
  end

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed plus random bench for count_stream_checker against a queue-based reference model.
module tb_count_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  count_in = '0;
  logic        sample_en = 1'b0;
  logic        err_valid;
  logic        err_ready = 1'b0;
  logic [7:0]  err_expected;
  logic [7:0]  err_actual;
  logic [15:0] wrap_count;
  logic [15:0] err_total;
  logic        overflow;
  logic        tracking;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_trk;
  int m_exp;
  int m_wrap;
  int m_err;
  bit m_ovf;
  int qe[$];
  int qa[$];

  count_stream_checker dut (
    .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en),
    .err_valid(err_valid), .err_ready(err_ready), .err_expected(err_expected),
    .err_actual(err_actual), .wrap_count(wrap_count), .err_total(err_total),
    .overflow(overflow), .tracking(tracking)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === 32'(expv))
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("err_valid", 32'(err_valid), (qe.size() != 0) ? 1 : 0);
    chk("err_expected", 32'(err_expected), (qe.size() != 0) ? qe[0] : 0);
    chk("err_actual", 32'(err_actual), (qa.size() != 0) ? qa[0] : 0);
    chk("wrap_count", 32'(wrap_count), m_wrap);
    chk("err_total", 32'(err_total), m_err);
    chk("overflow", 32'(overflow), int'(m_ovf));
    chk("tracking", 32'(tracking), int'(m_trk));
  endtask

  task automatic model_reset();
    m_trk = 0; m_exp = 0; m_wrap = 0; m_err = 0; m_ovf = 0;
    qe.delete(); qa.delete();
  endtask

  // one clock edge of the spec's rules, applied to pre-edge model state
  task automatic model_step(input bit se, input int ci, input bit rdy);
    bit popped;
    int occ;
    occ = qe.size();
    popped = rdy && (occ != 0);
    if (popped) begin
      void'(qe.pop_front());
      void'(qa.pop_front());
    end
    if (se) begin
      if (m_trk && ci != m_exp) begin
        if (m_err < 65535) m_err++;
        if (occ < 4 || popped) begin
          qe.push_back(m_exp);
          qa.push_back(ci);
        end else m_ovf = 1;
      end else if (m_trk && ci == 255) begin
        if (m_wrap < 65535) m_wrap++;
      end
      m_trk = 1;
      m_exp = (ci + 1) % 256;
    end
  endtask

  task automatic step(input bit se, input int ci, input bit rdy);
    sample_en = se;
    count_in  = 8'(ci);
    err_ready = rdy;
    model_step(se, ci, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample_en = 1'b0;
    err_ready = 1'b0;
  endtask

  initial begin
    int prev;
    // reset and a clean ascending run
    do_reset();
    for (int v = 0; v <= 40; v++) step(1, v, 1);
    chk("plan1_tracking", 32'(tracking), 1);
    chk("plan1_err_total", 32'(err_total), 0);
    chk("plan1_wrap", 32'(wrap_count), 0);

    // wrap through all-ones
    do_reset();
    for (int v = 250; v <= 261; v++) step(1, v % 256, 1);
    chk("plan2_wrap", 32'(wrap_count), 1);
    chk("plan2_err_total", 32'(err_total), 0);

    // single skip with consumer ready
    do_reset();
    step(1, 4, 1); step(1, 5, 1); step(1, 7, 1);
    chk("plan3_rec_exp", 32'(err_expected), 6);
    chk("plan3_rec_act", 32'(err_actual), 7);
    step(1, 8, 1);
    chk("plan3_drained", 32'(err_valid), 0);
    chk("plan3_err_total", 32'(err_total), 1);

    // five skips with consumer stalled: fifth dropped
    do_reset();
    step(1, 0, 0);
    for (int k = 1; k <= 5; k++) step(1, 2 * k, 0);
    chk("plan4_err_total", 32'(err_total), 5);
    chk("plan4_overflow", 32'(overflow), 1);
    for (int k = 0; k < 5; k++) step(0, 0, 1);
    chk("plan4_empty", 32'(err_valid), 0);

    // full FIFO with simultaneous pop and push
    do_reset();
    step(1, 0, 0);
    for (int k = 1; k <= 4; k++) step(1, 2 * k, 0);
    step(1, 10, 1);
    chk("plan5_overflow", 32'(overflow), 0);
    chk("plan5_occupancy", qe.size(), 4);
    for (int k = 0; k < 3; k++) step(0, 0, 1);
    chk("plan5_last_exp", 32'(err_expected), 9);
    chk("plan5_last_act", 32'(err_actual), 10);
    step(0, 0, 1);

    // reset mid-operation
    do_reset();
    step(1, 254, 0); step(1, 255, 0); step(1, 254, 0);
    step(1, 255, 0); step(1, 254, 0); step(1, 255, 0);
    chk("plan6_wrap_pre", 32'(wrap_count), 3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("plan6_valid_async", 32'(err_valid), 0);
    chk("plan6_wrap_async", 32'(wrap_count), 0);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 9, 0);
    step(1, 10, 0);
    chk("plan6_err_total", 32'(err_total), 0);

    // random stream with occasional skips, gaps and stalls
    do_reset();
    prev = $urandom % 256;
    for (int i = 0; i < 600; i++) begin
      bit se, rdy;
      int ci;
      se  = ($urandom % 4) != 0;
      rdy = ($urandom % 3) == 0;
      ci  = (($urandom % 6) == 0) ? int'($urandom % 256) : (prev + 1) % 256;
      if (se) prev = ci;
      step(se, ci, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
Downstream monitor stage for the 8-bit free-running counter. It samples the counter output on every enabled clock and checks that each value is the previous value plus one, modulo 2^WIDTH. Mismatches are logged into a small FIFO of (expected, actual) records, which a testbench or host drains through a valid/ready port. The block also keeps wrap-around and error totals for end-of-run pass/fail checks.

Parameters:
WIDTH, 8, width of the monitored count.
FIFO_DEPTH, 4, number of mismatch records held; must be a power of 2 and at least 2.
CNT_W, 16, width of the wrap_count and err_total counters.

Ports:
clk  input  1  clock; all logic is sampled on posedge.
rst  input  1  reset, asynchronous, active-high.
count_in  input  WIDTH  counter value under check.
sample_en  input  1  count_in is valid this cycle. When low, no state changes.
err_valid  output  1  FIFO head record is valid.
err_ready  input  1  consumer accepts the head record.
err_expected  output  WIDTH  expected value in the head record.
err_actual  output  WIDTH  observed value in the head record.
wrap_count  output  CNT_W  number of checked all-ones→0 wraps; saturates.
err_total  output  CNT_W  number of mismatches detected; saturates.
overflow  output  1  sticky flag: a mismatch was dropped because the FIFO was full.
tracking  output  1  high when the FSM is in TRACK.

Behaviour:
- Reset (async, applies immediately):
  - all outputs 0; FSM to IDLE; FIFO empty; expected register 0.
  - err_expected and err_actual read 0 while the FIFO is empty.
- FSM states: IDLE and TRACK.
  - IDLE: the first sample_en cycle latches expected <= count_in + 1 and moves to TRACK. No compare, wrap or error is counted on this cycle.
  - TRACK: stays in TRACK until reset. There is no exit on error.
- TRACK, sample_en high, count_in == expected:
  - expected <= count_in + 1, truncated to WIDTH (all-ones wraps to 0).
  - If count_in is all-ones, wrap_count increments.
- TRACK, sample_en high, count_in != expected:
  - Push {expected, count_in} into the FIFO.
  - err_total increments.
  - Resync: expected <= count_in + 1. No wrap is counted, even if count_in is all-ones.
- Saturation: wrap_count and err_total hold at 2^CNT_W-1 and never wrap.
- FIFO:
  - Registered storage with read/write pointers and a count.
  - err_valid = FIFO not empty; err_expected and err_actual are driven from the head entry.
  - Latency: a mismatch sampled at edge N gives err_valid high from edge N (visible the cycle after the sample). This holds only if the FIFO was empty.
  - Pop on the cycle where err_valid && err_ready; the head advances at that edge.
  - err_ready while empty is ignored.
- Full FIFO boundary:
  - A push with no pop drops the record and sets overflow. err_total still increments.
  - A push and pop in the same cycle while full both take effect; overflow is not set.
  - Push and pop in the same cycle at any other occupancy: the count is unchanged.
- overflow clears only on rst.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation discards FIFO contents and all counters immediately. err_valid drops with no handshake.

Optional Feature:
COUNT_CHECK_DISPLAY_EN
- Defined: on every detected mismatch, the block issues $display("CHECK ERR t=%t exp=%d act=%d", $time, expected, count_in) from the clocked block. On an overflow drop it also issues $display("CHECK OVERFLOW t=%t", $time).
- Not defined: no system tasks are compiled in and the block is fully synthesizable. Port behaviour is identical either way.

Test Plan:
- Reset, then feed 0,1,2,…,40 with sample_en=1 → tracking=1 after the first sample; err_total=0, wrap_count=0, err_valid never high.
- Feed 250 through 255, then 0 through 5 → wrap_count=1, err_total=0.
- Feed 4,5,7,8, err_ready=1 → one record exp=6 act=7, err_valid high for one cycle, err_total=1; 8 is accepted with no further error.
- err_ready=0, inject 5 separate skips (FIFO_DEPTH=4) → err_total=5, overflow=1; draining returns the first 4 records in order, then err_valid=0.
- FIFO full, err_ready=1 and a new mismatch on the same cycle → overflow stays 0, occupancy stays 4, the newest record is last out.
- Assert rst while the FIFO holds 2 records and wrap_count=3 → all outputs 0 immediately; next sample 9 is taken in IDLE with no error; next 10 is checked clean.
